// File: rtl/flags_wb_stage.sv
// Execute-to-writeback stage: derives ZF/SF/PF, buffers results in a 2-entry skid buffer, commits masked EFLAGS.
// Optional macro FLAGS_BYPASS_EN: eflags shows the post-commit value combinationally during a wb handshake.
module flags_wb_stage #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [1:0]        ex_opsize,
    input  logic              ex_cf,
    input  logic              ex_of,
    input  logic [4:0]        ex_flag_we,
    input  logic              flush,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_result,
    output logic [31:0]       eflags
);

    localparam int unsigned FLAG_W   = 5;
    localparam int unsigned EFLAGS_W = 32;
    localparam int unsigned CF_POS   = 0;
    localparam int unsigned PF_POS   = 2;
    localparam int unsigned ZF_POS   = 6;
    localparam int unsigned SF_POS   = 7;
    localparam int unsigned OF_POS   = 11;
    localparam logic [EFLAGS_W-1:0] EFLAGS_RST = EFLAGS_W'(32'h0000_0002);

    // flags/mask ordering: {OF,SF,ZF,PF,CF}
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;
        logic [FLAG_W-1:0] mask;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    entry_t                head_q, tail_q;
    entry_t                new_entry_c;
    logic                  ex_ready_q, wb_valid_q;
    logic [EFLAGS_W-1:0]   eflags_q, commit_c;
    logic                  zf_c, sf_c, pf_c;
    logic                  ex_hs_c, wb_hs_c;

    assign ex_hs_c = ex_valid & ex_ready_q & ~flush;
    assign wb_hs_c = wb_valid_q & wb_ready & ~flush;

    // Flags derived at accept time for the selected operand size
    always_comb begin
        zf_c = (ex_result == '0);
        sf_c = ex_result[DATA_W-1];
        case (ex_opsize)
            2'b00: begin
                zf_c = (ex_result[7:0] == 8'd0);
                sf_c = ex_result[7];
            end
            2'b01: begin
                zf_c = (ex_result[15:0] == 16'd0);
                sf_c = ex_result[15];
            end
            default: ;
        endcase
        pf_c = ~^ex_result[7:0];
        new_entry_c.result = ex_result;
        new_entry_c.flags  = {ex_of, sf_c, zf_c, pf_c, ex_cf};
        new_entry_c.mask   = ex_flag_we;
    end

    // Head entry's masked flags merged onto the architected register
    always_comb begin
        commit_c = eflags_q;
        if (head_q.mask[0]) commit_c[CF_POS] = head_q.flags[0];
        if (head_q.mask[1]) commit_c[PF_POS] = head_q.flags[1];
        if (head_q.mask[2]) commit_c[ZF_POS] = head_q.flags[2];
        if (head_q.mask[3]) commit_c[SF_POS] = head_q.flags[3];
        if (head_q.mask[4]) commit_c[OF_POS] = head_q.flags[4];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (ex_hs_c) state_d = S_ONE;
            S_ONE: begin
                if (ex_hs_c && !wb_hs_c)      state_d = S_TWO;
                else if (!ex_hs_c && wb_hs_c) state_d = S_EMPTY;
            end
            S_TWO:   if (wb_hs_c) state_d = S_ONE;
            default: state_d = S_EMPTY;
        endcase
        if (flush) state_d = S_EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            ex_ready_q <= 1'b1;
            wb_valid_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            eflags_q   <= EFLAGS_RST;
        end else begin
            state_q    <= state_d;
            ex_ready_q <= (state_d != S_TWO);
            wb_valid_q <= (state_d != S_EMPTY);
            if (wb_hs_c) eflags_q <= commit_c;
            case (state_q)
                S_EMPTY: if (ex_hs_c) head_q <= new_entry_c;
                S_ONE: begin
                    if (ex_hs_c && wb_hs_c) head_q <= new_entry_c;
                    else if (ex_hs_c)       tail_q <= new_entry_c;
                end
                S_TWO:   if (wb_hs_c) head_q <= tail_q;
                default: ;
            endcase
        end
    end

    assign ex_ready  = ex_ready_q;
    assign wb_valid  = wb_valid_q;
    assign wb_result = head_q.result;

`ifdef FLAGS_BYPASS_EN
    assign eflags = wb_hs_c ? commit_c : eflags_q;
`else
    assign eflags = eflags_q;
`endif

endmodule

// File: tb/tb_flags_wb_stage.sv
// Self-checking bench for flags_wb_stage: directed vector table, corner sequences, randomized model compare.
module tb_flags_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_result;
    logic [1:0]  ex_opsize;
    logic        ex_cf;
    logic        ex_of;
    logic [4:0]  ex_flag_we;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_result;
    logic [31:0] eflags;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    flags_wb_stage #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_result  (ex_result),
        .ex_opsize  (ex_opsize),
        .ex_cf      (ex_cf),
        .ex_of      (ex_of),
        .ex_flag_we (ex_flag_we),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_result  (wb_result),
        .eflags     (eflags)
    );

    typedef struct {
        logic [31:0] result;
        logic [1:0]  opsize;
        logic        cf;
        logic        of;
        logic [4:0]  we;
        logic [31:0] exp_eflags;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  flags;
        logic [4:0]  mask;
    } mentry_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags straight from the architectural definitions, {OF,SF,ZF,PF,CF}
    function automatic logic [4:0] ref_flags(input logic [31:0] r, input logic [1:0] op,
                                             input logic cf, input logic of);
        int unsigned w;
        logic [31:0] m;
        logic zf, sf, pf;
        w  = (op == 2'd0) ? 8 : (op == 2'd1) ? 16 : 32;
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        zf = ((r & m) == 32'd0);
        sf = r[w-1];
        pf = (($countones(r[7:0]) % 2) == 0);
        return {of, sf, zf, pf, cf};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] ef, input logic [4:0] fl, input logic [4:0] m);
        int pos[5] = '{0, 2, 6, 7, 11};
        for (int k = 0; k < 5; k++)
            if (m[k]) ef[pos[k]] = fl[k];
        return ef;
    endfunction

    task automatic drive(input logic v, input logic [31:0] r, input logic [1:0] op,
                         input logic cf, input logic of, input logic [4:0] we);
        ex_valid   = v;
        ex_result  = r;
        ex_opsize  = op;
        ex_cf      = cf;
        ex_of      = of;
        ex_flag_we = we;
    endtask

    vec_t        vecs[10];
    mentry_t     q[$];
    logic [31:0] m_eflags;
    logic [31:0] prev;
    logic [31:0] exp_ef;
    logic        hs_ex, hs_wb;

    initial begin
        vecs[0] = '{32'h0000_00FF, 2'b00, 1'b1, 1'b0, 5'h1F, 32'h0000_0087};
        vecs[1] = '{32'h0001_0000, 2'b01, 1'b0, 1'b0, 5'h1F, 32'h0000_0046};
        vecs[2] = '{32'h8000_0000, 2'b10, 1'b0, 1'b1, 5'h1F, 32'h0000_0886};
        vecs[3] = '{32'h0000_0001, 2'b11, 1'b1, 1'b1, 5'h1F, 32'h0000_0803};
        vecs[4] = '{32'h0000_0100, 2'b00, 1'b0, 1'b0, 5'h1F, 32'h0000_0046};
        vecs[5] = '{32'h0000_8003, 2'b01, 1'b0, 1'b0, 5'h1F, 32'h0000_0086};
        vecs[6] = '{32'h0000_0000, 2'b10, 1'b1, 1'b1, 5'h00, 32'h0000_0086};
        vecs[7] = '{32'h0000_0000, 2'b10, 1'b1, 1'b1, 5'h04, 32'h0000_00C6};
        vecs[8] = '{32'hFFFF_FFFF, 2'b10, 1'b1, 1'b0, 5'h01, 32'h0000_00C7};
        vecs[9] = '{32'h1234_5678, 2'b10, 1'b0, 1'b1, 5'h10, 32'h0000_08C7};

        rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
        drive(1'b0, 32'd0, 2'd0, 1'b0, 1'b0, 5'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        check("reset_eflags",    eflags,          32'h0000_0002);
        check("reset_wb_valid",  32'(wb_valid),   32'd0);
        check("reset_ex_ready",  32'(ex_ready),   32'd1);
        check("reset_wb_result", wb_result,       32'd0);

        // Table: accept, observe next cycle, check eflags after commit
        prev = 32'h0000_0002;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wb_ready = 1'b1;
            drive(1'b1, vecs[i].result, vecs[i].opsize, vecs[i].cf, vecs[i].of, vecs[i].we);
            @(negedge clk);
            ex_valid = 1'b0;
            #1;
            check($sformatf("vec%0d_wb_valid", i),  32'(wb_valid), 32'd1);
            check($sformatf("vec%0d_wb_result", i), wb_result,     vecs[i].result);
`ifndef FLAGS_BYPASS_EN
            check($sformatf("vec%0d_pre_commit", i), eflags, prev);
`else
            check($sformatf("vec%0d_bypass", i), eflags, vecs[i].exp_eflags);
`endif
            @(negedge clk); #1;
            check($sformatf("vec%0d_eflags", i),   eflags,          vecs[i].exp_eflags);
            check($sformatf("vec%0d_drained", i),  32'(wb_valid),   32'd0);
            prev = vecs[i].exp_eflags;
        end

        // Backpressure: A, B fill the buffer, C is held until a slot frees
        @(negedge clk);
        wb_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 2'b10, 1'b0, 1'b0, 5'd0);
        @(negedge clk); #1;
        check("bp_one_ready", 32'(ex_ready), 32'd1);
        check("bp_one_head",  wb_result,     32'hAAAA_0001);
        ex_result = 32'hBBBB_0002;
        @(negedge clk); #1;
        check("bp_two_ready", 32'(ex_ready), 32'd0);
        check("bp_two_head",  wb_result,     32'hAAAA_0001);
        ex_result = 32'hCCCC_0003;
        @(negedge clk); #1;
        check("bp_held_ready", 32'(ex_ready), 32'd0);
        check("bp_held_head",  wb_result,     32'hAAAA_0001);
        wb_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_pop_a_head",  wb_result,     32'hBBBB_0002);
        check("bp_pop_a_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        ex_valid = 1'b0;
        #1;
        check("bp_pop_b_head",  wb_result,     32'hCCCC_0003);
        check("bp_pop_b_valid", 32'(wb_valid), 32'd1);
        @(negedge clk); #1;
        check("bp_empty_valid", 32'(wb_valid), 32'd0);
        check("bp_eflags_hold", eflags,        32'h0000_08C7);

        // Flush with two entries and wb_ready high: nothing commits
        wb_ready = 1'b0;
        drive(1'b1, 32'd0, 2'b10, 1'b1, 1'b1, 5'h1F);
        repeat (2) @(negedge clk);
        #1;
        check("fl_full", 32'(ex_ready), 32'd0);
        flush = 1'b1; wb_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0;
        #1;
        check("fl_wb_valid", 32'(wb_valid), 32'd0);
        check("fl_ex_ready", 32'(ex_ready), 32'd1);
        check("fl_eflags",   eflags,        32'h0000_08C7);

        // Reset while an entry is buffered
        wb_ready = 1'b0;
        drive(1'b1, 32'h0000_0000, 2'b10, 1'b1, 1'b1, 5'h1F);
        @(negedge clk);
        ex_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; wb_ready = 1'b1;
        #1;
        check("rst_mid_valid",  32'(wb_valid), 32'd0);
        check("rst_mid_result", wb_result,     32'd0);
        check("rst_mid_eflags", eflags,        32'h0000_0002);

        // Randomized traffic against the queue model
        m_eflags = 32'h0000_0002;
        q.delete();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            @(negedge clk);
            r = $urandom;
            case ($urandom_range(0, 3))
                0: r = r & 32'hFFFF_FF00;
                1: r = r & 32'hFFFF_0000;
                2: r = 32'd0;
                default: ;
            endcase
            drive(1'($urandom_range(0, 1)), r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            wb_ready = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 15) == 0);
            hs_ex = ex_valid && (q.size() < 2) && !flush;
            hs_wb = wb_ready && (q.size() > 0) && !flush;
            #1;
            check("rnd_wb_valid", 32'(wb_valid), 32'(q.size() > 0));
            check("rnd_ex_ready", 32'(ex_ready), 32'(q.size() < 2));
            if (q.size() > 0) check("rnd_wb_result", wb_result, q[0].result);
            exp_ef = m_eflags;
`ifdef FLAGS_BYPASS_EN
            if (hs_wb) exp_ef = merge(m_eflags, q[0].flags, q[0].mask);
`endif
            check("rnd_eflags", eflags, exp_ef);
            @(posedge clk);
            if (flush) begin
                q.delete();
            end else begin
                if (hs_wb) begin
                    m_eflags = merge(m_eflags, q[0].flags, q[0].mask);
                    void'(q.pop_front());
                end
                if (hs_ex) q.push_back('{ex_result, ref_flags(ex_result, ex_opsize, ex_cf, ex_of), ex_flag_we});
            end
        end

        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
